// File: rtl/hazard_scoreboard.sv
// Operand-hazard controller: tracks in-flight destinations for DEPTH stages
// past operand read and decides stall / forward / register-file per source.
module hazard_scoreboard #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned AW          = 5,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned NSRC        = 2,
  parameter int unsigned ALU_STAGE   = 1,
  parameter int unsigned LOAD_STAGE  = 2,
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [NSRC*AW-1:0]   iss_rs,
  input  logic [NSRC-1:0]      iss_rs_used,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 iss_we,
  input  logic                 iss_load,
  input  logic                 flush,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic                 stall,
  output logic                 iss_fire,
  output logic [NSRC-1:0]      fwd_valid,
  output logic [NSRC*XLEN-1:0] fwd_data,
  output logic [15:0]          stall_count
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          we;
    logic [SW-1:0] rdy;
  } entry_t;

  // Index k-1 holds the instruction k stages ahead of operand read.
  entry_t      ent_q [DEPTH];
  entry_t      ent_d [DEPTH];
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0] stall_req;

  // Per source: pick the youngest matching producer, forward if ready, else stall.
  always_comb begin
    logic          found;
    logic [AW-1:0] rs;
    stall_req = '0;
    fwd_valid = '0;
    fwd_data  = '0;
    found     = 1'b0;
    rs        = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      found = 1'b0;
      rs    = iss_rs[i*AW +: AW];
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found && ent_q[k].valid && ent_q[k].we && (ent_q[k].rd == rs) &&
            (rs != '0) && iss_rs_used[i]) begin
          found = 1'b1;
          if (SW'(k + 1) >= ent_q[k].rdy) begin
            fwd_valid[i]                = 1'b1;
            fwd_data[i*XLEN +: XLEN]    = stage_data[k*XLEN +: XLEN];
          end else begin
            stall_req[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stall       = iss_valid & (|stall_req);
  assign iss_fire    = iss_valid & ~stall & ~flush;
  assign stall_count = stall_cnt_q;

  // Shift entries: new issue or bubble enters stage 1; flush bubbles the young ones.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ent_d[k] = '0;
    end
    if (iss_fire) begin
      ent_d[0].valid = 1'b1;
      ent_d[0].rd    = iss_rd;
      ent_d[0].we    = iss_we;
      ent_d[0].rdy   = iss_load ? SW'(LOAD_STAGE) : SW'(ALU_STAGE);
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      ent_d[k] = ent_q[k-1];
      if (flush && (k <= FLUSH_DEPTH)) begin
        ent_d[k].valid = 1'b0;
      end
    end
  end

  // Saturating stall-cycle counter; flushed cycles do not count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent_q[k] <= ent_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic, checked against a model that tracks instructions by issue cycle.
module tb_hazard_scoreboard;

  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int DEPTH = 3;
  localparam int NSRC = 2;
  localparam int ALU_STAGE = 1;
  localparam int LOAD_STAGE = 2;
  localparam int FLUSH_DEPTH = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  iss_valid;
  logic [NSRC*AW-1:0]    iss_rs;
  logic [NSRC-1:0]       iss_rs_used;
  logic [AW-1:0]         iss_rd;
  logic                  iss_we;
  logic                  iss_load;
  logic                  flush;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic                  stall;
  logic                  iss_fire;
  logic [NSRC-1:0]       fwd_valid;
  logic [NSRC*XLEN-1:0]  fwd_data;
  logic [15:0]           stall_count;

  hazard_scoreboard #(
    .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NSRC(NSRC),
    .ALU_STAGE(ALU_STAGE), .LOAD_STAGE(LOAD_STAGE), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_rs(iss_rs),
    .iss_rs_used(iss_rs_used), .iss_rd(iss_rd), .iss_we(iss_we),
    .iss_load(iss_load), .flush(flush), .stage_data(stage_data),
    .stall(stall), .iss_fire(iss_fire), .fwd_valid(fwd_valid),
    .fwd_data(fwd_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: each in-flight instruction remembers the cycle it issued;
  // its stage is simply (current cycle - issue cycle).
  typedef struct {
    int ic;
    int rd;
    bit we;
    int rdy;
  } rec_t;

  rec_t        q[$];
  int          cyc = 0;
  logic [31:0] sd [1:DEPTH];
  logic [15:0] m_cnt = 0;
  logic        e_stall, e_fire;
  logic        e_fv [NSRC];
  logic [31:0] e_fd [NSRC];

  task automatic eval_model();
    logic [NSRC-1:0] req;
    req = '0;
    for (int i = 0; i < NSRC; i++) begin
      int bk;
      int br;
      int rs;
      bk = 0;
      br = 0;
      rs = int'(iss_rs[i*AW +: AW]);
      e_fv[i] = 1'b0;
      e_fd[i] = '0;
      foreach (q[j]) begin
        int k;
        k = cyc - q[j].ic;
        if (k >= 1 && k <= DEPTH && q[j].we && q[j].rd == rs && rs != 0 &&
            iss_rs_used[i] && (bk == 0 || k < bk)) begin
          bk = k;
          br = q[j].rdy;
        end
      end
      if (bk != 0) begin
        if (bk >= br) begin
          e_fv[i] = 1'b1;
          e_fd[i] = sd[bk];
        end else begin
          req[i] = 1'b1;
        end
      end
    end
    e_stall = iss_valid && (req != '0);
    e_fire  = iss_valid && !e_stall && !flush;
  endtask

  task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit we, input bit ld, input bit fl);
    iss_valid   = v;
    iss_rs      = {AW'(rs1), AW'(rs0)};
    iss_rs_used = used;
    iss_rd      = AW'(rd);
    iss_we      = we;
    iss_load    = ld;
    flush       = fl;
    for (int k = 1; k <= DEPTH; k++) sd[k] = $urandom;
  endtask

  task automatic pack_sd();
    for (int k = 1; k <= DEPTH; k++) stage_data[(k-1)*XLEN +: XLEN] = sd[k];
  endtask

  // One clock: compare everything against the model, then advance model state.
  task automatic step();
    pack_sd();
    #1;
    eval_model();
    chk("stall", stall, e_stall);
    chk("fire", iss_fire, e_fire);
    for (int i = 0; i < NSRC; i++) begin
      chk($sformatf("fwd_valid%0d", i), fwd_valid[i], e_fv[i]);
      chk($sformatf("fwd_data%0d", i), fwd_data[i*XLEN +: XLEN], e_fd[i]);
    end
    chk("stall_count", stall_count, m_cnt);
    @(posedge clk);
    if (flush) begin
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (cyc - q[j].ic >= 1 && cyc - q[j].ic <= FLUSH_DEPTH) q.delete(j);
      end
    end
    if (e_fire) q.push_back('{ic: cyc, rd: int'(iss_rd), we: iss_we,
                              rdy: (iss_load ? LOAD_STAGE : ALU_STAGE)});
    if (e_stall && !flush && m_cnt != 16'hFFFF) m_cnt++;
    cyc++;
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (cyc - q[j].ic > DEPTH) q.delete(j);
    end
    @(negedge clk);
  endtask

  logic [15:0] cnt_snap;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    pack_sd();
    #3;
    chk("rst_stall", stall, 1'b0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_count", stall_count, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ALU producer x5, consumer next cycle forwards from stage 1.
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0); step();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0); sd[1] = 32'h0000_1234; pack_sd(); #1;
    chk("alu_stall", stall, 1'b0);
    chk("alu_fv", fwd_valid[0], 1'b1);
    chk("alu_fd", fwd_data[31:0], 32'h0000_1234);
    step();

    // Load x6, consumer stalls one cycle then forwards from stage 2.
    drive(1, 0, 0, 2'b00, 6, 1, 1, 0); step();
    drive(1, 6, 0, 2'b01, 0, 0, 0, 0); pack_sd(); #1;
    chk("lu_stall", stall, 1'b1);
    step();
    chk("lu_count", stall_count, 16'd1);
    sd[2] = 32'hCAFE_0006; pack_sd(); #1;
    chk("lu_stall2", stall, 1'b0);
    chk("lu_fire", iss_fire, 1'b1);
    chk("lu_fd", fwd_data[31:0], 32'hCAFE_0006);
    step();

    // x7 in stages 1 and 3: youngest wins; young load stalls despite ready old one.
    for (int pass = 0; pass < 2; pass++) begin
      drive(1, 0, 0, 2'b00, 7, 1, 0, 0); step();
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0); step();
      drive(1, 0, 0, 2'b00, 7, 1, pass[0], 0); step();
      drive(1, 7, 0, 2'b01, 0, 0, 0, 0);
      sd[1] = 32'h1111_0007; sd[3] = 32'h3333_0007; pack_sd(); #1;
      if (pass == 0) chk("young_fd", fwd_data[31:0], 32'h1111_0007);
      else           chk("young_load_stall", stall, 1'b1);
      step();
      if (pass == 1) step();
    end

    // x0 never matches; unused source never matches.
    drive(1, 0, 0, 2'b00, 0, 1, 0, 0); step();
    drive(1, 0, 0, 2'b01, 0, 0, 0, 0); pack_sd(); #1;
    chk("x0_stall", stall, 1'b0);
    chk("x0_fv", fwd_valid[0], 1'b0);
    step();
    drive(1, 0, 0, 2'b00, 9, 1, 0, 0); step();
    drive(1, 0, 9, 2'b01, 0, 0, 0, 0); pack_sd(); #1;
    chk("unused_fv", fwd_valid[1], 1'b0);
    step();

    // Flush kills stage-1 load of x8 and the stalled consumer.
    drive(1, 0, 0, 2'b00, 8, 1, 1, 0); step();
    cnt_snap = stall_count;
    drive(1, 8, 0, 2'b01, 0, 0, 0, 1); pack_sd(); #1;
    chk("flush_fire", iss_fire, 1'b0);
    step();
    drive(1, 8, 0, 2'b01, 0, 0, 0, 0); pack_sd(); #1;
    chk("flush_stall", stall, 1'b0);
    chk("flush_fv", fwd_valid[0], 1'b0);
    chk("flush_count", stall_count, cnt_snap);
    step();

    // Saturation: preload counter, then three load-use stalls.
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 16'hFFFE;
    for (int n = 0; n < 3; n++) begin
      drive(1, 0, 0, 2'b00, 11, 1, 1, 0); step();
      drive(1, 11, 0, 2'b01, 0, 0, 0, 0); step();
      step();
    end
    chk("sat_count", stall_count, 16'hFFFF);

    // Async reset mid-stall clears hazard and counter without a clock edge.
    drive(1, 0, 0, 2'b00, 12, 1, 1, 0); step();
    drive(1, 12, 0, 2'b01, 0, 0, 0, 0); pack_sd(); #1;
    chk("pre_rst_stall", stall, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_count", stall_count, 16'd0);
    q.delete();
    m_cnt = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    step();

    // Random traffic over a small register range to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(3) != 0), $urandom_range(7), $urandom_range(7),
            2'($urandom_range(3)), $urandom_range(7), ($urandom_range(4) != 0),
            ($urandom_range(2) == 0), ($urandom_range(7) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
